// File: rtl/mem_burst_initiator_if.sv
// Bundle of request, write-beat, response and memory-helper signals for mem_burst_initiator.
// master = initiator side, slave = requester/memory environment side.
interface mem_burst_initiator_if #(
    parameter int LEN_W = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [63:0]      req_index;
    logic [LEN_W-1:0] req_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [63:0]      wr_data;
    logic [63:0]      wr_mask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic             rsp_last;
    logic             wr_done;
    logic             req_err;
    logic             busy;
    logic             mem_enable;
    logic             mem_r_enable;
    logic [63:0]      mem_r_index;
    logic [63:0]      mem_r_data;
    logic             mem_w_enable;
    logic [63:0]      mem_w_index;
    logic [63:0]      mem_w_data;
    logic [63:0]      mem_w_mask;

    modport master (
        input  req_valid, req_write, req_index, req_len,
        input  wr_valid, wr_data, wr_mask, rsp_ready, mem_r_data,
        output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last,
        output wr_done, req_err, busy, mem_enable,
        output mem_r_enable, mem_r_index, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
    );

    modport slave (
        output req_valid, req_write, req_index, req_len,
        output wr_valid, wr_data, wr_mask, rsp_ready, mem_r_data,
        input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last,
        input  wr_done, req_err, busy, mem_enable,
        input  mem_r_enable, mem_r_index, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
    );
endinterface

// File: rtl/mem_burst_initiator.sv
// Burst requester for the word-indexed memory helper: one request -> per-cycle strobes, reads via a response FIFO.
// Optional macro MEM_RANGE_CHECK_EN rejects requests that reach past MEM_WORDS.
module mem_burst_initiator #(
    parameter int RSP_DEPTH = 4,
    parameter int LEN_W     = 8
`ifdef MEM_RANGE_CHECK_EN
    ,
    parameter logic [63:0] MEM_WORDS = 64'd536870912
`endif
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    mem_burst_initiator_if.master bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t           state_q;
    logic [63:0]      idx_q;
    logic [LEN_W-1:0] cnt_q;
    logic             inflight_q;
    logic             inflight_last_q;
    logic             wr_done_q;
    logic             req_err_q;
    logic [64:0]      fifo_q [RSP_DEPTH];
    logic [PW-1:0]    wp_q;
    logic [PW-1:0]    rp_q;
    logic [CW-1:0]    count_q;

    logic             accept_s;
    logic             range_bad_s;
    logic             issue_s;
    logic             beat_s;
    logic             last_s;
    logic             push_s;
    logic             pop_s;
    logic [CW:0]      occ_s;

    // Handshakes; a read is issued only if its data is guaranteed a FIFO slot (queued + in flight).
    always_comb begin
        accept_s = bus.req_valid && (state_q == ST_IDLE);
        occ_s    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue_s  = (state_q == ST_READ) && (occ_s < DEPTH_C);
        beat_s   = (state_q == ST_WRITE) && bus.wr_valid;
        last_s   = (cnt_q == {LEN_W{1'b0}});
        push_s   = inflight_q;
        pop_s    = (count_q != {CW{1'b0}}) && bus.rsp_ready;
    end

`ifdef MEM_RANGE_CHECK_EN
    logic [64:0] end_idx_s;

    // 65-bit end index so a wrapping request counts as out of range.
    always_comb begin
        end_idx_s   = {1'b0, bus.req_index} + {{(65-LEN_W){1'b0}}, bus.req_len};
        range_bad_s = (end_idx_s >= {1'b0, MEM_WORDS});
    end
`else
    assign range_bad_s = 1'b0;
`endif

    // Burst FSM, beat counter, in-flight tracking and FIFO pointers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= ST_IDLE;
            idx_q           <= 64'd0;
            cnt_q           <= {LEN_W{1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_done_q       <= 1'b0;
            req_err_q       <= 1'b0;
            wp_q            <= {PW{1'b0}};
            rp_q            <= {PW{1'b0}};
            count_q         <= {CW{1'b0}};
        end else begin
            wr_done_q       <= 1'b0;
            req_err_q       <= 1'b0;
            inflight_q      <= issue_s;
            inflight_last_q <= issue_s && last_s;
            if (push_s) begin
                wp_q <= wp_q + PW'(1);
            end
            if (pop_s) begin
                rp_q <= rp_q + PW'(1);
            end
            count_q <= count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        idx_q <= bus.req_index;
                        cnt_q <= bus.req_len;
                        if (range_bad_s) begin
                            req_err_q <= 1'b1;
                        end else if (bus.req_write) begin
                            state_q <= ST_WRITE;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue_s) begin
                        idx_q <= idx_q + 64'd1;
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (last_s) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_IDLE;
                end
                ST_WRITE: begin
                    if (beat_s) begin
                        idx_q <= idx_q + 64'd1;
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (last_s) begin
                            state_q   <= ST_IDLE;
                            wr_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Response storage: data plus last-beat flag; contents are don't-care while empty.
    always_ff @(posedge clock_i) begin
        if (push_s) begin
            fifo_q[wp_q] <= {inflight_last_q, bus.mem_r_data};
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.wr_ready     = (state_q == ST_WRITE);
    assign bus.mem_r_enable = issue_s;
    assign bus.mem_r_index  = idx_q;
    assign bus.mem_w_enable = beat_s;
    assign bus.mem_w_index  = idx_q;
    assign bus.mem_w_data   = beat_s ? bus.wr_data : 64'd0;
    assign bus.mem_w_mask   = beat_s ? bus.wr_mask : 64'd0;
    assign bus.mem_enable   = issue_s || beat_s;
    assign bus.rsp_valid    = (count_q != {CW{1'b0}});
    assign bus.rsp_data     = bus.rsp_valid ? fifo_q[rp_q][63:0] : 64'd0;
    assign bus.rsp_last     = bus.rsp_valid ? fifo_q[rp_q][64] : 1'b0;
    assign bus.wr_done      = wr_done_q;
    assign bus.req_err      = req_err_q;
    assign bus.busy         = (state_q != ST_IDLE) || inflight_q;
endmodule

// File: tb/tb_mem_burst_initiator.sv
// Self-checking bench for mem_burst_initiator: directed scenarios plus random bursts against a queue model.
module tb_mem_burst_initiator;
    localparam int RSP_DEPTH = 4;
    localparam int LEN_W     = 8;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } rsp_t;

    typedef struct {
        logic [63:0] idx;
        logic [63:0] data;
        logic [63:0] mask;
    } wr_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          strobes  = 0;
    int          pops     = 0;
    logic [63:0] exp_rd_idx [$];
    rsp_t        exp_rsp [$];
    wr_t         exp_wr [$];
    rsp_t        mon_r;
    wr_t         mon_w;

    always #5 clk = ~clk;

    mem_burst_initiator_if #(.LEN_W(LEN_W)) bus ();

    mem_burst_initiator #(.RSP_DEPTH(RSP_DEPTH), .LEN_W(LEN_W)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    function automatic logic [63:0] mem_fn(input logic [63:0] idx);
        return (idx * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory helper model: registered read data one cycle after the strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.mem_r_data <= 64'd0;
        else if (bus.mem_r_enable === 1'b1) bus.mem_r_data <= mem_fn(bus.mem_r_index);
    end

    // Monitor: strobes, responses and writes against the expected queues.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rw_exclusive", {63'd0, bus.mem_r_enable & bus.mem_w_enable}, 64'd0);
            check("mem_enable", {63'd0, bus.mem_enable}, {63'd0, bus.mem_r_enable | bus.mem_w_enable});
            if (bus.mem_r_enable) begin
                check("rd_flow", {63'd0, (strobes - pops) < RSP_DEPTH}, 64'd1);
                if (exp_rd_idx.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
                else check("rd_index", bus.mem_r_index, exp_rd_idx.pop_front());
                strobes++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_data", bus.rsp_data, mon_r.data);
                    check("rsp_last", {63'd0, bus.rsp_last}, {63'd0, mon_r.last});
                end
                pops++;
            end
            if (bus.mem_w_enable) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_index", bus.mem_w_index, mon_w.idx);
                    check("wr_data", bus.mem_w_data, mon_w.data);
                    check("wr_mask", bus.mem_w_mask, mon_w.mask);
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [63:0] idx, input logic [LEN_W-1:0] len,
                          output int waits, output logic ok);
`ifdef MEM_RANGE_CHECK_EN
        logic [64:0] end_idx;
        end_idx = {1'b0, idx} + {57'd0, len};
        ok = (end_idx < 65'd536870912);
`else
        ok = 1'b1;
`endif
        if (ok && !wr) begin
            for (int k = 0; k <= int'(len); k++) begin
                exp_rd_idx.push_back(idx + 64'(k));
                exp_rsp.push_back('{mem_fn(idx + 64'(k)), (k == int'(len))});
            end
        end
        bus.req_write = wr;
        bus.req_index = idx;
        bus.req_len   = len;
        bus.req_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("req_wait_bound", {63'd0, waits < 50}, 64'd1);
    endtask

    task automatic check_rejected();
        check("req_err_pulse", {63'd0, bus.req_err}, 64'd1);
        check("req_err_idle", {63'd0, bus.req_ready}, 64'd1);
        check("req_err_nostrobe", {63'd0, bus.mem_enable}, 64'd0);
        @(posedge clk);
        #1;
        check("req_err_clear", {63'd0, bus.req_err}, 64'd0);
    endtask

    task automatic wait_read(input logic rnd);
        int cyc;
        cyc = 0;
        while ((exp_rsp.size() != 0 || exp_rd_idx.size() != 0) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("rd_done_bound", {63'd0, cyc < 500}, 64'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rd_busy_clear", {63'd0, bus.busy}, 64'd0);
        check("rd_rsp_empty", {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    task automatic read_burst(input logic [63:0] idx, input logic [LEN_W-1:0] len, input logic rnd);
        int   waits;
        logic ok;
        do_req(1'b0, idx, len, waits, ok);
        if (ok) wait_read(rnd);
        else check_rejected();
    endtask

    task automatic write_burst(input logic [63:0] idx, input logic [LEN_W-1:0] len,
                               input logic alt, input logic [63:0] mask);
        int          waits;
        int          beats;
        int          cyc;
        logic        ok;
        logic        v;
        logic [63:0] d;
        logic [63:0] m;
        do_req(1'b1, idx, len, waits, ok);
        if (!ok) begin
            check_rejected();
        end else begin
            beats = 0;
            cyc   = 0;
            while (beats <= int'(len) && cyc < 600) begin
                v = alt ? (cyc % 2 == 0) : ($urandom_range(0, 9) < 7);
                d = {$urandom, $urandom};
                m = alt ? mask : {$urandom, $urandom};
                bus.wr_valid = v;
                bus.wr_data  = d;
                bus.wr_mask  = m;
                if (v) begin
                    check("wr_ready", {63'd0, bus.wr_ready}, 64'd1);
                    exp_wr.push_back('{idx + 64'(beats), d, m});
                    beats++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            bus.wr_valid = 1'b0;
            check("wr_beats", 64'(beats), 64'(int'(len) + 1));
            check("wr_done_pulse", {63'd0, bus.wr_done}, 64'd1);
            check("wr_idle", {63'd0, bus.req_ready}, 64'd1);
            @(posedge clk);
            #1;
            check("wr_done_clear", {63'd0, bus.wr_done}, 64'd0);
            check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        end
    endtask

    initial begin
        int          waits;
        int          base;
        logic        ok;
        logic [63:0] ridx;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_index = 64'd0;
        bus.req_len   = {LEN_W{1'b0}};
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 64'd0;
        bus.wr_mask   = 64'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_enable", {63'd0, bus.mem_enable}, 64'd0);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_wr_ready", {63'd0, bus.wr_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rel_wr_done", {63'd0, bus.wr_done}, 64'd0);
        check("rel_req_err", {63'd0, bus.req_err}, 64'd0);

        // Read 0x100 len 3, consumer always ready: latency, throughput and busy timing.
        do_req(1'b0, 64'h100, 8'd3, waits, ok);
        check("t1_strobe0", {63'd0, bus.mem_r_enable}, 64'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check("t1_rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, k >= 2});
            check("t1_strobe", {63'd0, bus.mem_r_enable}, {63'd0, k <= 3});
            check("t1_busy", {63'd0, bus.busy}, {63'd0, k <= 4});
        end
        wait_read(1'b0);

        // Read len 7 with consumer stalled: exactly RSP_DEPTH strobes, then the rest.
        bus.rsp_ready = 1'b0;
        base = strobes;
        do_req(1'b0, 64'h200, 8'd7, waits, ok);
        repeat (8) @(posedge clk);
        #1;
        check("t2_stall_strobes", 64'(strobes - base), 64'(RSP_DEPTH));
        check("t2_rsp_held", {63'd0, bus.rsp_valid}, 64'd1);
        wait_read(1'b0);
        check("t2_total_strobes", 64'(strobes - base), 64'd8);

        write_burst(64'h20, 8'd2, 1'b1, 64'hFF);

        read_burst(64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 1'b0);

        // Reset in the middle of a stalled read with two entries queued.
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 64'h300, 8'd7, waits, ok);
        repeat (3) @(posedge clk);
        #1;
        check("t5_queued", {63'd0, bus.rsp_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_r_enable", {63'd0, bus.mem_r_enable}, 64'd0);
        check("t5_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("t5_rst_rsp_data", bus.rsp_data, 64'd0);
        check("t5_rst_busy", {63'd0, bus.busy}, 64'd0);
        exp_rd_idx.delete();
        exp_rsp.delete();
        strobes = 0;
        pops    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t5_rel_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("t5_rel_req_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.rsp_ready = 1'b1;
        do_req(1'b0, 64'h40, 8'd1, waits, ok);
        check("t5_accept_now", 64'(waits), 64'd0);
        if (ok) wait_read(1'b0);
        else check_rejected();

`ifdef MEM_RANGE_CHECK_EN
        read_burst(64'd536870910, 8'd1, 1'b0);
        read_burst(64'd536870910, 8'd2, 1'b0);
`endif

        // Random mix of read and write bursts, random backpressure and beat gaps.
        for (int n = 0; n < 10; n++) begin
            ridx = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 4000));
            if ($urandom_range(0, 1) == 1) write_burst(ridx, 8'($urandom_range(0, 12)), 1'b0, 64'd0);
            else read_burst(ridx, 8'($urandom_range(0, 12)), 1'b1);
        end

`ifndef MEM_RANGE_CHECK_EN
        check("req_err_tied", {63'd0, bus.req_err}, 64'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
